sopc_data_bus: RTL and testbench
================================

# sopc_data_bus

Parametrised data-side interconnect for the MIPS32 SOPC: replaces the single point-to-point CPU↔data-RAM link with one master port fanned out to NUM_SLV slaves (RAM, timer, UART, GPIO …). Decodes the top address bits, drives a request/acknowledge handshake toward the selected slave, stalls the CPU memory stage until completion and reports unmapped or timed-out accesses as a one-cycle bus error. Sits between `openmips` (ram_* ports, stall into the pipeline controller) and the peripheral slaves inside the SOPC top.

## Interface
Parameters:
- `DATA_W`, 32, data width; byte-select width is DATA_W/8
- `ADDR_W`, 32, address width
- `NUM_SLV`, 4, number of slaves, 1..16
- `TIMEOUT`, 16, max ACCESS cycles before bus error, 2..255

Ports (clock and reset: one clock; reset is asynchronous and active-high):
- `clk` in 1 — system clock, all state on rising edge
- `rst` in 1 — asynchronous, active-high reset
- `m_ce_i` in 1 — master request
- `m_we_i` in 1 — 1 = write, 0 = read
- `m_addr_i` in ADDR_W — byte address; slave index = m_addr_i[ADDR_W-1:ADDR_W-4]
- `m_sel_i` in DATA_W/8 — byte enables
- `m_data_i` in DATA_W — write data
- `m_data_o` out DATA_W — registered read data
- `m_stall_o` out 1 — hold request, access not complete
- `m_err_o` out 1 — one-cycle bus-error pulse
- `err_addr_o` out ADDR_W — address of most recent errored access
- `s_ce_o` out NUM_SLV — one-hot slave select
- `s_we_o`, `s_addr_o`, `s_sel_o`, `s_data_o` out 1/ADDR_W/DATA_W/8/DATA_W — shared, latched request fields
- `s_data_i` in NUM_SLV*DATA_W — slave k read data at bits [k*DATA_W +: DATA_W]
- `s_ack_i` in NUM_SLV — slave k completion

## Operation
- FSM states: IDLE, ACCESS, RESP, ERR.
- IDLE: if m_ce_i, latch we/addr/sel/data and index idx; idx < NUM_SLV → ACCESS, else → ERR. Cycle counter cleared.
- ACCESS: s_ce_o = one-hot(idx), shared s_* = latched fields. If s_ack_i[idx] → capture read data (reads only) into m_data_o, → RESP. Else if counter == TIMEOUT-1 → ERR. Else counter+1.
- Ack from a non-selected slave ignored. Ack and timeout in same cycle: ack wins.
- RESP: s_ce_o = 0, m_stall_o = 0; → IDLE. New request not accepted in RESP.
- ERR: m_err_o = 1, m_data_o = 0, err_addr_o = latched addr, m_stall_o = 0; → IDLE.
- Writes leave m_data_o unchanged.
- m_stall_o = (IDLE & m_ce_i) | ACCESS; forced 0 while rst high.
- Master keeps request stable while m_stall_o = 1; advances on the cycle m_stall_o = 0.

## Timing
- Reset (async, immediate): state IDLE, counter 0, s_ce_o 0, s_we_o/s_addr_o/s_sel_o/s_data_o 0, m_data_o 0, m_err_o 0, err_addr_o 0, m_stall_o 0. Reset mid-ACCESS drops s_ce_o in the same cycle, no RESP/ERR emitted.
- Best-case latency (ack in first ACCESS cycle): request seen cycle 0, ACCESS cycle 1, RESP cycle 2 with m_data_o valid; 2 stall cycles.
- Slave with W wait cycles: W+2 stall cycles.
- Unmapped: IDLE → ERR, m_err_o in cycle 1, 1 stall cycle.
- Timeout: ACCESS lasts exactly TIMEOUT cycles, m_err_o in cycle TIMEOUT+1.
- Back-to-back throughput: one access per 3 cycles minimum (IDLE, ACCESS, RESP).
- s_ce_o held high for whole ACCESS, never high in IDLE/RESP/ERR.

## Test plan
- Reset: assert rst mid-ACCESS → s_ce_o = 0, m_stall_o = 0 that cycle, all outputs at reset values.
- Read slave 0 at 0x0000_0010, slave acks in first cycle with 0xDEADBEEF → m_stall_o high 2 cycles, m_data_o = 0xDEADBEEF in RESP, m_err_o = 0.
- Write slave 2 at 0x2000_0004, sel 4'b0011, data 0x1234_5678, ack after 3 waits → s_ce_o = 4'b0100 for 4 cycles, s_sel_o = 4'b0011, m_data_o unchanged.
- Unmapped read 0xF000_0000 (NUM_SLV=4) → no s_ce_o, m_err_o pulse cycle 1, err_addr_o = 0xF000_0000, m_data_o = 0.
- Slave 1 never acks, slave 3 acks spuriously → ack ignored, ERR after exactly 16 ACCESS cycles, err_addr_o = request address.
- Ack on final timeout cycle → RESP taken, no m_err_o; back-to-back reads to slaves 0/1 complete every 3 cycles with correct data.

Source files
------------

// File: rtl/sopc_data_bus.sv
`default_nettype none
// ============================================================================
// sopc_data_bus : MIPS32 SOPC data-side interconnect, one master to NUM_SLV
//                 slaves with req/ack handshake, stall, timeout and bus error.
// Revision      : 1.0
// ============================================================================
module sopc_data_bus #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      m_ce_i,
  input  logic                      m_we_i,
  input  logic [ADDR_W-1:0]         m_addr_i,
  input  logic [DATA_W/8-1:0]       m_sel_i,
  input  logic [DATA_W-1:0]         m_data_i,
  output logic [DATA_W-1:0]         m_data_o,
  output logic                      m_stall_o,
  output logic                      m_err_o,
  output logic [ADDR_W-1:0]         err_addr_o,
  output logic [NUM_SLV-1:0]        s_ce_o,
  output logic                      s_we_o,
  output logic [ADDR_W-1:0]         s_addr_o,
  output logic [DATA_W/8-1:0]       s_sel_o,
  output logic [DATA_W-1:0]         s_data_o,
  input  logic [NUM_SLV*DATA_W-1:0] s_data_i,
  input  logic [NUM_SLV-1:0]        s_ack_i
);

  localparam int         SEL_W      = DATA_W / 8;
  localparam logic [4:0] C_NUM_SLV  = 5'(NUM_SLV);
  localparam logic [7:0] C_LAST_CYC = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    ERR    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [3:0]          idx_q, idx_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;

  logic [3:0]          req_idx;
  logic                req_mapped;
  logic [NUM_SLV-1:0]  slv_hot;
  logic                ack_sel;
  logic [DATA_W-1:0]   rd_mux;

  assign req_idx    = m_addr_i[ADDR_W-1 -: 4];
  assign req_mapped = ({1'b0, req_idx} < C_NUM_SLV);

  generate
    for (genvar k = 0; k < NUM_SLV; k++) begin : g_slv_hot
      assign slv_hot[k] = (idx_q == 4'(k));
    end
  endgenerate

  // Acks from slaves other than the selected one are masked off here.
  assign ack_sel = |(s_ack_i & slv_hot);

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (slv_hot[k]) begin
        rd_mux = rd_mux | s_data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    we_d       = we_q;
    addr_d     = addr_q;
    sel_d      = sel_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_addr_d = err_addr_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (m_ce_i) begin
          idx_d   = req_idx;
          we_d    = m_we_i;
          addr_d  = m_addr_i;
          sel_d   = m_sel_i;
          wdata_d = m_data_i;
          if (req_mapped) begin
            state_d = ACCESS;
          end else begin
            state_d    = ERR;
            rdata_d    = '0;
            err_addr_d = m_addr_i;
          end
        end
      end
      ACCESS: begin
        // Ack is checked before the timeout so a last-cycle ack still completes.
        if (ack_sel) begin
          if (!we_q) begin
            rdata_d = rd_mux;
          end
          state_d = RESP;
        end else if (cnt_q == C_LAST_CYC) begin
          state_d    = ERR;
          rdata_d    = '0;
          err_addr_d = addr_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      sel_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      sel_q      <= sel_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Stall depends on the live request in IDLE so the master holds from cycle 0.
  assign m_stall_o  = ~rst & (((state_q == IDLE) & m_ce_i) | (state_q == ACCESS));
  assign m_err_o    = (state_q == ERR);
  assign m_data_o   = rdata_q;
  assign err_addr_o = err_addr_q;
  assign s_ce_o     = (state_q == ACCESS) ? slv_hot : '0;
  assign s_we_o     = we_q;
  assign s_addr_o   = addr_q;
  assign s_sel_o    = sel_q;
  assign s_data_o   = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_sopc_data_bus.sv
`default_nettype none
// tb_sopc_data_bus : directed scoreboard bench for sopc_data_bus (4 slaves, timeout 16).
module tb_sopc_data_bus;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NS = 4;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              m_ce_i, m_we_i;
  logic [AW-1:0]     m_addr_i;
  logic [DW/8-1:0]   m_sel_i;
  logic [DW-1:0]     m_data_i;
  logic [DW-1:0]     m_data_o;
  logic              m_stall_o, m_err_o;
  logic [AW-1:0]     err_addr_o;
  logic [NS-1:0]     s_ce_o;
  logic              s_we_o;
  logic [AW-1:0]     s_addr_o;
  logic [DW/8-1:0]   s_sel_o;
  logic [DW-1:0]     s_data_o;
  logic [NS*DW-1:0]  s_data_i;
  logic [NS-1:0]     s_ack_i;

  logic [DW-1:0]     slv_rd [NS];
  logic [DW-1:0]     model_rdata;
  longint            cyc = 0;
  int                tests = 0;
  int                fails = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    logic [AW-1:0] addr;
  } exp_t;
  exp_t sb [$];

  sopc_data_bus #(.DATA_W(DW), .ADDR_W(AW), .NUM_SLV(NS), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m_ce_i(m_ce_i), .m_we_i(m_we_i), .m_addr_i(m_addr_i), .m_sel_i(m_sel_i),
    .m_data_i(m_data_i), .m_data_o(m_data_o), .m_stall_o(m_stall_o),
    .m_err_o(m_err_o), .err_addr_o(err_addr_o), .s_ce_o(s_ce_o),
    .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_sel_o(s_sel_o), .s_data_o(s_data_o),
    .s_data_i(s_data_i), .s_ack_i(s_ack_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    s_data_i = '0;
    for (int k = 0; k < NS; k++) s_data_i[k*DW +: DW] = slv_rd[k];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One master access; ack_after = ACCESS cycle index of the selected slave's ack (-1 = never).
  task automatic access(input string tag, input logic we, input logic [AW-1:0] addr,
                        input logic [3:0] sel, input logic [DW-1:0] wdata,
                        input int ack_after, input logic [NS-1:0] spur, input int exp_stall);
    int            idx, c, ce_cycles, exp_ce;
    bit            mapped, done;
    logic [NS-1:0] hot;
    exp_t          e, got_e;
    idx    = int'(addr[31:28]);
    mapped = (idx < NS);
    hot    = '0;
    if (mapped) hot[idx] = 1'b1;
    e.err  = !mapped || ack_after < 0 || ack_after >= TO;
    e.addr = addr;
    if (e.err)   e.data = '0;
    else if (we) e.data = model_rdata;
    else         e.data = slv_rd[idx];
    model_rdata = e.data;
    sb.push_back(e);
    exp_ce = !mapped ? 0 : (e.err ? TO : ack_after + 1);

    m_ce_i = 1'b1; m_we_i = we; m_addr_i = addr; m_sel_i = sel; m_data_i = wdata;
    c = 0; ce_cycles = 0; done = 0;
    while (!done && c < 100) begin
      s_ack_i = spur;
      if (mapped && c >= 1 && (c - 1) == ack_after) s_ack_i[idx] = 1'b1;
      #1;
      if (!m_stall_o) begin
        done = 1;
        chk({tag, "_ce_end"}, 64'(s_ce_o), 64'(0));
      end else begin
        chk({tag, "_ce"}, 64'(s_ce_o), (c == 0) ? 64'(0) : 64'(hot));
        if (s_ce_o != '0) ce_cycles++;
        if (c == 1 && mapped) begin
          chk({tag, "_s_we"},   64'(s_we_o),   64'(we));
          chk({tag, "_s_addr"}, 64'(s_addr_o), 64'(addr));
          chk({tag, "_s_sel"},  64'(s_sel_o),  64'(sel));
          chk({tag, "_s_data"}, 64'(s_data_o), 64'(wdata));
        end
        @(posedge clk); #1;
        c++;
      end
    end
    chk({tag, "_completed"}, 64'(done), 64'(1));
    got_e = sb.pop_front();
    chk({tag, "_stall_cycles"}, 64'(c), 64'(exp_stall));
    chk({tag, "_ce_cycles"},    64'(ce_cycles), 64'(exp_ce));
    chk({tag, "_m_data"},       64'(m_data_o), 64'(got_e.data));
    chk({tag, "_m_err"},        64'(m_err_o),  64'(got_e.err));
    if (got_e.err) chk({tag, "_err_addr"}, 64'(err_addr_o), 64'(got_e.addr));
    @(posedge clk); #1;
    m_ce_i = 1'b0; s_ack_i = '0;
    #1;
    chk({tag, "_err_pulse_end"}, 64'(m_err_o), 64'(0));
    chk({tag, "_m_data_hold"},   64'(m_data_o), 64'(got_e.data));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    longint t0, t1, t2;
    s_ack_i = '0; m_we_i = 1'b0; m_sel_i = '0; m_data_i = '0;
    slv_rd[0] = 32'hDEAD_BEEF; slv_rd[1] = 32'h1111_1111;
    slv_rd[2] = 32'h2222_2222; slv_rd[3] = 32'h3333_3333;
    model_rdata = '0;
    m_ce_i = 1'b1; m_addr_i = 32'h0000_0010;
    #3;
    chk("rst_stall",    64'(m_stall_o),  64'(0));
    chk("rst_s_ce",     64'(s_ce_o),     64'(0));
    chk("rst_m_data",   64'(m_data_o),   64'(0));
    chk("rst_m_err",    64'(m_err_o),    64'(0));
    chk("rst_err_addr", 64'(err_addr_o), 64'(0));
    chk("rst_s_addr",   64'(s_addr_o),   64'(0));
    @(negedge clk); rst = 1'b0; m_ce_i = 1'b0;
    @(posedge clk); #1;

    access("rd0",     1'b0, 32'h0000_0010, 4'hF,    32'h0,          0,  4'b0000, 2);
    access("wr2",     1'b1, 32'h2000_0004, 4'b0011, 32'h1234_5678,  3,  4'b0000, 5);
    access("unmap",   1'b0, 32'hF000_0000, 4'hF,    32'h0,          0,  4'b0000, 1);
    access("tmo",     1'b0, 32'h1000_0040, 4'hF,    32'h0,          -1, 4'b1000, TO + 1);
    slv_rd[1] = 32'hCAFE_F00D;
    access("lastack", 1'b0, 32'h1000_0044, 4'hF,    32'h0,          TO - 1, 4'b0000, TO + 1);

    slv_rd[0] = 32'h0BAD_F00D; slv_rd[1] = 32'h5EED_1234;
    t0 = cyc;
    access("b2b0",    1'b0, 32'h0000_0100, 4'hF,    32'h0,          0,  4'b0000, 2);
    t1 = cyc;
    access("b2b1",    1'b0, 32'h1000_0008, 4'hF,    32'h0,          0,  4'b0000, 2);
    t2 = cyc;
    chk("b2b_period0", 64'(t1 - t0), 64'(3));
    chk("b2b_period1", 64'(t2 - t1), 64'(3));

    // Asynchronous reset in the middle of an access that would never be acked.
    m_ce_i = 1'b1; m_we_i = 1'b1; m_addr_i = 32'h1000_0000; m_sel_i = 4'hC;
    m_data_i = 32'hA5A5_A5A5; s_ack_i = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_s_ce", 64'(s_ce_o), 64'(4'b0010));
    rst = 1'b1;
    #1;
    chk("mid_rst_s_ce",     64'(s_ce_o),     64'(0));
    chk("mid_rst_stall",    64'(m_stall_o),  64'(0));
    chk("mid_rst_m_data",   64'(m_data_o),   64'(0));
    chk("mid_rst_err_addr", 64'(err_addr_o), 64'(0));
    chk("mid_rst_m_err",    64'(m_err_o),    64'(0));
    chk("mid_rst_s_fields", {31'(0), s_we_o, s_addr_o}, 64'(0));
    chk("mid_rst_s_sel",    64'(s_sel_o),    64'(0));
    chk("mid_rst_s_data",   64'(s_data_o),   64'(0));
    @(posedge clk); #1;
    chk("held_rst_err",   64'(m_err_o),   64'(0));
    chk("held_rst_stall", 64'(m_stall_o), 64'(0));
    m_ce_i = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_s_ce", 64'(s_ce_o), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
